// File: rtl/priority_encoder.sv
// Registered N-input priority encoder: y is the index of the highest set bit of a, valid = |a.
// Optional build macro PRIENC_ONEHOT_EN adds a registered one-hot copy of the winner (y_onehot).
module priority_encoder #(
  parameter int N = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [N-1:0]           a,
  output logic [$clog2(N)-1:0]   y,
`ifdef PRIENC_ONEHOT_EN
  output logic [N-1:0]           y_onehot,
`endif
  output logic                   valid
);

  localparam int W = $clog2(N);

  // Sample interface: en=1 captures a on the rising edge; en=0 holds every output.
  // There is no backpressure; the result is visible exactly one clock after capture.
  logic [W-1:0] idx_c;
  logic         any_c;
  logic [N-1:0] onehot_c;

  // Ascending scan, so the last (highest) set bit wins.
  always_comb begin
    idx_c    = '0;
    any_c    = 1'b0;
    onehot_c = '0;
    for (int i = 0; i < N; i++) begin
      if (a[i]) begin
        idx_c       = W'(i);
        any_c       = 1'b1;
        onehot_c    = '0;
        onehot_c[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y     <= '0;
      valid <= 1'b0;
    end else if (en) begin
      y     <= idx_c;
      valid <= any_c;
    end
  end

`ifdef PRIENC_ONEHOT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_onehot <= '0;
    end else if (en) begin
      y_onehot <= onehot_c;
    end
  end
`else
  // Without the one-hot port the winner vector has no consumer.
  logic unused_onehot;
  assign unused_onehot = ^onehot_c;
`endif

endmodule

// File: tb/tb_priority_encoder.sv
// Bench for priority_encoder: reset, N=4 table sweep, hold, zero/one, N=5 instance,
// and randomized traffic against a log2-based reference model.
module tb_priority_encoder;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] a;
  logic [1:0] y;
  logic       valid;
  logic [4:0] a5;
  logic [2:0] y5;
  logic       valid5;
`ifdef PRIENC_ONEHOT_EN
  logic [3:0] y_onehot;
  logic [4:0] y5_onehot;
`endif

  int vectors;
  int miscompares;

  logic [2:0] exp_q[$];   // {valid, y} for the N=4 instance
  logic [3:0] exp5_q[$];  // {valid, y} for the N=5 instance

  typedef struct {
    logic [3:0] a;
    logic [1:0] y;
    logic       v;
  } vec_t;
  vec_t tbl[16];

  priority_encoder #(.N(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .y(y),
`ifdef PRIENC_ONEHOT_EN
    .y_onehot(y_onehot),
`endif
    .valid(valid)
  );

  priority_encoder #(.N(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a5), .y(y5),
`ifdef PRIENC_ONEHOT_EN
    .y_onehot(y5_onehot),
`endif
    .valid(valid5)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int ref_idx(input int unsigned v);
    int idx;
    idx = 0;
    while (v > 1) begin
      v = v / 2;
      idx++;
    end
    return idx;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk4(input string nm, input int ey, input int ev);
    chk({nm, ".y"}, int'(y), ey);
    chk({nm, ".valid"}, int'(valid), ev);
`ifdef PRIENC_ONEHOT_EN
    chk({nm, ".y_onehot"}, int'(y_onehot), ev != 0 ? (1 << ey) : 0);
`endif
  endtask

  task automatic chk5(input string nm, input int ey, input int ev);
    chk({nm, ".y5"}, int'(y5), ey);
    chk({nm, ".valid5"}, int'(valid5), ev);
`ifdef PRIENC_ONEHOT_EN
    chk({nm, ".y5_onehot"}, int'(y5_onehot), ev != 0 ? (1 << ey) : 0);
`endif
  endtask

  // ---------------- driver ----------------
  // Drive at a falling edge; outputs are checked at the following falling edge.
  task automatic drive(input logic [3:0] av, input logic ev);
    @(negedge clk);
    a  = av;
    en = ev;
  endtask

  task automatic step_chk(input string nm, input logic [3:0] av, input logic ev,
                          input int ey, input int evld);
    drive(av, ev);
    @(negedge clk);
    chk4(nm, ey, evld);
  endtask

  initial begin
    logic [2:0] e4;
    logic [3:0] e5;
    logic [1:0] m_y;
    logic       m_v;
    logic [2:0] m5_y;
    logic       m5_v;

    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    a     = '0;
    a5    = '0;

    // Expected mapping for N=4, written out from the range table.
    for (int i = 0; i < 16; i++) begin
      tbl[i].a = 4'(i);
      tbl[i].y = (i >= 8) ? 2'd3 : (i >= 4) ? 2'd2 : (i >= 2) ? 2'd1 : 2'd0;
      tbl[i].v = (i != 0);
    end

    // Reset state, held across clock edges.
    repeat (3) @(negedge clk);
    chk4("reset", 0, 0);
    chk5("reset", 0, 0);
    rst_n = 1'b1;

    // Back-to-back sweep: a new value every cycle, each checked one cycle later.
    @(negedge clk);
    en = 1'b1;
    a  = tbl[0].a;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk4($sformatf("sweep[%0d]", i), int'(tbl[i].y), int'(tbl[i].v));
      if (i < 15) a = tbl[i + 1].a;
    end

    // Asynchronous reset mid-cycle with y=3, valid=1.
    step_chk("preload8", 4'd8, 1'b1, 3, 1);
    #2 rst_n = 1'b0;
    #1 chk4("async_reset", 0, 0);
    @(negedge clk);
    chk4("reset_held", 0, 0);
    rst_n = 1'b1;
    en    = 1'b0;
    a     = 4'd8;
    @(negedge clk);
    chk4("post_reset_en0", 0, 0);
    step_chk("first_update", 4'd8, 1'b1, 3, 1);

    // Hold with en=0 while a changes.
    for (int k = 0; k < 3; k++)
      step_chk($sformatf("hold[%0d]", k), 4'd1, 1'b0, 3, 1);
    step_chk("hold_release", 4'd1, 1'b1, 0, 1);

    // valid separates a=0 from a=1.
    step_chk("zero_in", 4'd0, 1'b1, 0, 0);
    step_chk("one_in", 4'd1, 1'b1, 0, 1);

    // One-hot example 4'b0110 (y_onehot also checked inside chk4 when built in).
    step_chk("a0110", 4'b0110, 1'b1, 2, 1);
    step_chk("a0000", 4'b0000, 1'b1, 0, 0);

    // N=5 corners.
    @(negedge clk);
    a5 = 5'b10000;
    en = 1'b1;
    @(negedge clk);
    chk5("n5_10000", 4, 1);
    a5 = 5'b01111;
    @(negedge clk);
    chk5("n5_01111", 3, 1);

    // Randomized traffic; the first cycle forces en=1 so the model starts in step.
    m_y = '0; m_v = 1'b0; m5_y = '0; m5_v = 1'b0;
    for (int c = 0; c < 300; c++) begin
      a  = 4'($urandom_range(0, 15));
      a5 = 5'($urandom_range(0, 31));
      en = (c == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (en) begin
        m_y  = 2'(ref_idx(a));
        m_v  = (a != 0);
        m5_y = 3'(ref_idx(a5));
        m5_v = (a5 != 0);
      end
      exp_q.push_back({m_v, m_y});
      exp5_q.push_back({1'b0, m5_v, m5_y});
      @(negedge clk);
      e4 = exp_q.pop_front();
      e5 = exp5_q.pop_front();
      chk4("rand4", int'(e4[1:0]), int'(e4[2]));
      chk5("rand5", int'(e5[2:0]), int'(e5[3]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
